// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer: state encoding and
// instruction-word field positions.
package instr_sequencer_pkg;

   localparam int unsigned InstrW = 9;
   localparam int unsigned CBit   = 8;
   localparam int unsigned LbBit  = 7;
   localparam int unsigned LaBit  = 6;
   localparam int unsigned SMsb   = 5;
   localparam int unsigned SLsb   = 4;
   localparam int unsigned ImmMsb = 3;
   localparam int unsigned ImmLsb = 0;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StFetch = 3'd1,
      StWait  = 3'd2,
      StExec  = 3'd3,
      StPause = 3'd4,
      StHalt  = 3'd5,
      StErr   = 3'd6
   } seq_state_e;

   function automatic logic is_busy(input seq_state_e s);
      return (s == StFetch) || (s == StWait) || (s == StExec) || (s == StPause);
   endfunction

endpackage

// File: rtl/instr_sequencer_fetch_timer.sv
// Fetch watchdog: clearable, saturating down-counter; expired once TIMEOUT-1
// enabled cycles have elapsed since the last clear.
module instr_sequencer_fetch_timer #(
   parameter int unsigned TIMEOUT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int unsigned CntW = $clog2(TIMEOUT);
   localparam logic [CntW-1:0] Load = CntW'(TIMEOUT - 1);

   logic [CntW-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_q <= Load;
      end else if (en && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign expired = (count_q == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: PC, ROM fetch handshake, execute strobe,
// halt/timeout supervision. Single-step support is built only with SEQ_STEP_EN.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int unsigned PC_W     = 4,
   parameter int unsigned PROG_LEN = 16,
   parameter int unsigned WRAP     = 0,
   parameter int unsigned TIMEOUT  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt_req,
   input  logic              step_mode,
   input  logic              step,
   output logic              mem_req,
   output logic [PC_W-1:0]   mem_addr,
   input  logic [InstrW-1:0] mem_data,
   input  logic              mem_valid,
   output logic [InstrW-1:0] im,
   output logic              exec_en,
   output logic [PC_W-1:0]   pc,
   output logic              busy,
   output logic              halted,
   output logic              err
);

   localparam logic [PC_W-1:0] LastPc = PC_W'(PROG_LEN - 1);

   seq_state_e        state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [InstrW-1:0] im_q, im_d;
   logic              halt_pend_q, halt_pend_d;
   logic              timer_clear, timer_en, timer_expired;
   logic              at_last;

`ifndef SEQ_STEP_EN
   logic unused_step;
   assign unused_step = step_mode ^ step;
`endif

   instr_sequencer_fetch_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_fetch_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (timer_clear),
      .en     (timer_en),
      .expired(timer_expired)
   );

   assign at_last = (pc_q == LastPc);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      im_d        = im_q;
      halt_pend_d = halt_pend_q;
      timer_clear = 1'b0;
      timer_en    = 1'b0;

      if (is_busy(state_q) && halt_req) begin
         halt_pend_d = 1'b1;
      end

      unique case (state_q)
         StIdle, StHalt, StErr: begin
            // A halt arriving with the start is kept: stop after the first instruction.
            if (start) begin
               pc_d        = '0;
               halt_pend_d = halt_req;
               state_d     = StFetch;
            end
         end
         StFetch: begin
            timer_clear = 1'b1;
            state_d     = StWait;
         end
         StWait: begin
            if (mem_valid) begin
               im_d    = mem_data;
               state_d = StExec;
            end else if (timer_expired) begin
               state_d = StErr;
            end else begin
               timer_en = 1'b1;
            end
         end
         StExec: begin
            if (halt_pend_q || halt_req) begin
               halt_pend_d = 1'b0;
               state_d     = StHalt;
            end else if (at_last && (WRAP == 0)) begin
               halt_pend_d = 1'b0;
               state_d     = StHalt;
            end else begin
               pc_d = at_last ? '0 : pc_q + 1'b1;
`ifdef SEQ_STEP_EN
               state_d = step_mode ? StPause : StFetch;
`else
               state_d = StFetch;
`endif
            end
         end
`ifdef SEQ_STEP_EN
         StPause: begin
            if (halt_pend_q || halt_req) begin
               halt_pend_d = 1'b0;
               state_d     = StHalt;
            end else if (step) begin
               state_d = StFetch;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         pc_q        <= '0;
         im_q        <= '0;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         im_q        <= im_d;
         halt_pend_q <= halt_pend_d;
      end
   end

   assign mem_req  = (state_q == StFetch);
   assign mem_addr = pc_q;
   assign im       = im_q;
   assign exec_en  = (state_q == StExec);
   assign pc       = pc_q;
   assign busy     = is_busy(state_q);
   assign halted   = (state_q == StHalt);
   assign err      = (state_q == StErr);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a halting and a wrapping instance share
// stimulus; a behavioural program/memory model predicts fetch addresses and words.
module tb_instr_sequencer;

   localparam int PcW     = 4;
   localparam int ProgLen = 4;
   localparam int Timeout = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst, start, halt_req, step_mode, step, mem_valid, sel;
   logic [8:0]     mem_data;

   logic           mem_req0, exec_en0, busy0, halted0, err0;
   logic           mem_req1, exec_en1, busy1, halted1, err1;
   logic [PcW-1:0] mem_addr0, pc0, mem_addr1, pc1;
   logic [8:0]     im0, im1;

   logic           mem_req_s, exec_en_s, busy_s, halted_s, err_s;
   logic [PcW-1:0] mem_addr_s, pc_s;
   logic [8:0]     im_s;

   instr_sequencer #(.PC_W(PcW), .PROG_LEN(ProgLen), .WRAP(0), .TIMEOUT(Timeout)) u_dut_halt (
      .clk(clk), .rst(rst), .start(start & ~sel), .halt_req(halt_req), .step_mode(step_mode),
      .step(step), .mem_req(mem_req0), .mem_addr(mem_addr0), .mem_data(mem_data),
      .mem_valid(mem_valid), .im(im0), .exec_en(exec_en0), .pc(pc0), .busy(busy0),
      .halted(halted0), .err(err0)
   );

   instr_sequencer #(.PC_W(PcW), .PROG_LEN(ProgLen), .WRAP(1), .TIMEOUT(Timeout)) u_dut_wrap (
      .clk(clk), .rst(rst), .start(start & sel), .halt_req(halt_req), .step_mode(step_mode),
      .step(step), .mem_req(mem_req1), .mem_addr(mem_addr1), .mem_data(mem_data),
      .mem_valid(mem_valid), .im(im1), .exec_en(exec_en1), .pc(pc1), .busy(busy1),
      .halted(halted1), .err(err1)
   );

   assign mem_req_s  = sel ? mem_req1  : mem_req0;
   assign exec_en_s  = sel ? exec_en1  : exec_en0;
   assign busy_s     = sel ? busy1     : busy0;
   assign halted_s   = sel ? halted1   : halted0;
   assign err_s      = sel ? err1      : err0;
   assign mem_addr_s = sel ? mem_addr1 : mem_addr0;
   assign pc_s       = sel ? pc1       : pc0;
   assign im_s       = sel ? im1       : im0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   // Program model: next address to fetch/execute, executions seen, memory latency state.
   int exp_addr, exec_cnt, fetch_cyc, fetch_lat, fetch_a, cnt;
   int lat_lo = 0, lat_hi = 0;
   bit pend = 0, no_resp = 0, noise = 1;
   int exec_cycles[$];
   logic [8:0] rom[ProgLen];

   task automatic tick();
      logic [PcW-1:0] want_addr;
      @(posedge clk);
      #1;
      start = 1'b0;
      halt_req = 1'b0;
      step = 1'b0;
      cyc++;
      want_addr = PcW'(exp_addr);
      if (mem_req_s === 1'b1) begin
         checks++;
         if (mem_addr_s !== want_addr) begin
            errors++;
            $display("FAIL fetch_addr: got %0d want %0d (cycle %0d)", mem_addr_s, want_addr, cyc);
         end
         fetch_cyc = cyc;
         fetch_a = exp_addr;
         pend = 1'b1;
         cnt = int'($urandom_range(lat_hi, lat_lo));
         fetch_lat = cnt;
      end
      if (exec_en_s === 1'b1) begin
         checks++;
         if (im_s !== rom[exp_addr]) begin
            errors++;
            $display("FAIL exec_im: got %h want %h", im_s, rom[exp_addr]);
         end
         checks++;
         if (pc_s !== want_addr) begin
            errors++;
            $display("FAIL exec_pc: got %0d want %0d", pc_s, want_addr);
         end
         checks++;
         if (cyc - fetch_cyc != 2 + fetch_lat) begin
            errors++;
            $display("FAIL exec_latency: got %0d want %0d", cyc - fetch_cyc, 2 + fetch_lat);
         end
         exec_cycles.push_back(cyc);
         exec_cnt++;
         exp_addr = (exp_addr + 1) % ProgLen;
      end
      mem_valid = 1'b0;
      mem_data = 9'($urandom);
      if (mem_req_s === 1'b1) begin
         mem_valid = noise ? 1'($urandom) : 1'b0;
      end else if (pend) begin
         if (!no_resp) begin
            if (cnt == 0) begin
               mem_valid = 1'b1;
               mem_data = rom[fetch_a];
               pend = 1'b0;
            end else begin
               cnt--;
            end
         end
      end else if (noise) begin
         mem_valid = 1'($urandom);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      pend = 1'b0;
      no_resp = 1'b0;
      exp_addr = 0;
      exec_cnt = 0;
      exec_cycles.delete();
   endtask

   task automatic wait_halt(input int max, input string name);
      int n = 0;
      while (halted_s !== 1'b1 && err_s !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      checks++;
      if (halted_s !== 1'b1) begin
         errors++;
         $display("FAIL %s_halt: halted=%b err=%b after %0d cycles, want halted=1", name, halted_s,
                  err_s, n);
      end
   endtask

   task automatic wait_exec(input int target, input int max, input string name);
      int n = 0;
      while (exec_cnt < target && n < max) begin
         tick();
         n++;
      end
      checks++;
      if (exec_cnt < target) begin
         errors++;
         $display("FAIL %s_exec_wait: got %0d executions want %0d", name, exec_cnt, target);
      end
   endtask

   task automatic test_reset();
      start = 1'b1;
      halt_req = 1'b1;
      do_reset();
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         checks++;
         if ({mem_req_s, exec_en_s, busy_s, halted_s, err_s} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags[%0d]: got %b want 00000", s,
                     {mem_req_s, exec_en_s, busy_s, halted_s, err_s});
         end
         checks++;
         if ({pc_s, mem_addr_s} !== '0) begin
            errors++;
            $display("FAIL reset_pc[%0d]: got pc=%0d addr=%0d want 0", s, pc_s, mem_addr_s);
         end
         checks++;
         if (im_s !== 9'h0) begin
            errors++;
            $display("FAIL reset_im[%0d]: got %h want 000", s, im_s);
         end
      end
      sel = 1'b0;
      lat_lo = 3;
      lat_hi = 3;
      start = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({busy_s, mem_req_s, exec_en_s, pc_s} !== '0) begin
         errors++;
         $display("FAIL reset_mid_fetch: got busy=%b req=%b exec=%b pc=%0d want all 0", busy_s,
                  mem_req_s, exec_en_s, pc_s);
      end
      lat_lo = 0;
      lat_hi = 0;
   endtask

   task automatic test_first_fetch();
      do_reset();
      start = 1'b1;
      tick();
      checks++;
      if (mem_req_s !== 1'b1 || busy_s !== 1'b1) begin
         errors++;
         $display("FAIL first_req: got req=%b busy=%b want 1 1", mem_req_s, busy_s);
      end
      tick();
      checks++;
      if (mem_req_s !== 1'b0 || exec_en_s !== 1'b0) begin
         errors++;
         $display("FAIL first_wait: got req=%b exec=%b want 0 0", mem_req_s, exec_en_s);
      end
      tick();
      checks++;
      if (exec_en_s !== 1'b1 || im_s !== 9'h0A1) begin
         errors++;
         $display("FAIL first_exec: got exec=%b im=%h want 1 0a1", exec_en_s, im_s);
      end
      tick();
      checks++;
      if (pc_s !== PcW'(1) || exec_en_s !== 1'b0) begin
         errors++;
         $display("FAIL first_pc: got pc=%0d exec=%b want 1 0", pc_s, exec_en_s);
      end
      wait_halt(40, "zero_wait");
      checks++;
      if (exec_cnt != ProgLen || pc_s !== PcW'(ProgLen - 1)) begin
         errors++;
         $display("FAIL zero_wait_run: got execs=%0d pc=%0d want %0d %0d", exec_cnt, pc_s,
                  ProgLen, ProgLen - 1);
      end
      for (int i = 1; i < exec_cycles.size(); i++) begin
         checks++;
         if (exec_cycles[i] - exec_cycles[i-1] != 3) begin
            errors++;
            $display("FAIL exec_spacing[%0d]: got %0d want 3", i,
                     exec_cycles[i] - exec_cycles[i-1]);
         end
      end
   endtask

   task automatic test_random_latency();
      lat_lo = 0;
      lat_hi = 3;
      exp_addr = 0;
      exec_cnt = 0;
      start = 1'b1;
      tick();
      wait_halt(100, "rand_lat");
      checks++;
      if (exec_cnt != ProgLen || pc_s !== PcW'(ProgLen - 1)) begin
         errors++;
         $display("FAIL rand_lat_run: got execs=%0d pc=%0d want %0d %0d", exec_cnt, pc_s,
                  ProgLen, ProgLen - 1);
      end
   endtask

   task automatic test_wrap();
      int halted_seen = 0;
      sel = 1'b1;
      do_reset();
      lat_lo = 0;
      lat_hi = 2;
      start = 1'b1;
      for (int n = 0; n < 200 && exec_cnt < 3 * ProgLen; n++) begin
         tick();
         if (halted_s === 1'b1) halted_seen++;
      end
      checks++;
      if (exec_cnt < 3 * ProgLen || halted_seen != 0 || busy_s !== 1'b1) begin
         errors++;
         $display("FAIL wrap_run: got execs=%0d halted_cycles=%0d busy=%b want %0d 0 1",
                  exec_cnt, halted_seen, busy_s, 3 * ProgLen);
      end
      do_reset();
      sel = 1'b0;
   endtask

   task automatic test_halt_req();
      int n = 0;
      do_reset();
      lat_lo = 1;
      lat_hi = 1;
      start = 1'b1;
      do begin
         tick();
         n++;
      end while (!(mem_req_s === 1'b1 && mem_addr_s === PcW'(2)) && n < 50);
      tick();
      halt_req = 1'b1;
      tick();
      wait_halt(20, "halt_req");
      checks++;
      if (exec_cnt != 3 || pc_s !== PcW'(2)) begin
         errors++;
         $display("FAIL halt_req_stop: got execs=%0d pc=%0d want 3 2", exec_cnt, pc_s);
      end
      lat_lo = 0;
      lat_hi = 0;
   endtask

   task automatic test_timeout();
      do_reset();
      no_resp = 1'b1;
      start = 1'b1;
      tick();
      for (int k = 1; k <= Timeout; k++) begin
         tick();
         checks++;
         if (err_s !== 1'b0 || busy_s !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early[%0d]: got err=%b busy=%b want 0 1", k, err_s, busy_s);
         end
      end
      tick();
      checks++;
      if (err_s !== 1'b1 || busy_s !== 1'b0 || halted_s !== 1'b0) begin
         errors++;
         $display("FAIL timeout_err: got err=%b busy=%b halted=%b want 1 0 0", err_s, busy_s,
                  halted_s);
      end
      no_resp = 1'b0;
      exp_addr = 0;
      exec_cnt = 0;
      start = 1'b1;
      tick();
      checks++;
      if (err_s !== 1'b0 || mem_req_s !== 1'b1) begin
         errors++;
         $display("FAIL timeout_restart: got err=%b req=%b want 0 1", err_s, mem_req_s);
      end
      wait_halt(60, "after_err");
      checks++;
      if (exec_cnt != ProgLen) begin
         errors++;
         $display("FAIL after_err_run: got execs=%0d want %0d", exec_cnt, ProgLen);
      end
   endtask

   task automatic test_start_rules();
      do_reset();
      start = 1'b1;
      halt_req = 1'b1;
      tick();
      wait_halt(20, "start_halt");
      checks++;
      if (exec_cnt != 1 || pc_s !== PcW'(0)) begin
         errors++;
         $display("FAIL start_with_halt: got execs=%0d pc=%0d want 1 0", exec_cnt, pc_s);
      end
      do_reset();
      start = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      start = 1'b1;
      tick();
      tick();
      start = 1'b1;
      tick();
      wait_halt(60, "start_busy");
      checks++;
      if (exec_cnt != ProgLen || pc_s !== PcW'(ProgLen - 1)) begin
         errors++;
         $display("FAIL start_busy_ignored: got execs=%0d pc=%0d want %0d %0d", exec_cnt, pc_s,
                  ProgLen, ProgLen - 1);
      end
   endtask

   task automatic test_step();
      do_reset();
      step_mode = 1'b1;
      start = 1'b1;
      tick();
`ifdef SEQ_STEP_EN
      for (int i = 1; i <= ProgLen; i++) begin
         wait_exec(i, 20, "step");
         if (i < ProgLen) begin
            for (int k = 0; k < 3; k++) begin
               tick();
               checks++;
               if (busy_s !== 1'b1 || mem_req_s !== 1'b0 || exec_cnt != i) begin
                  errors++;
                  $display("FAIL step_pause[%0d]: got busy=%b req=%b execs=%0d want 1 0 %0d", i,
                           busy_s, mem_req_s, exec_cnt, i);
               end
            end
            step = 1'b1;
            tick();
         end
      end
      wait_halt(10, "step_end");
`else
      for (int n = 0; n < 60 && halted_s !== 1'b1; n++) begin
         step = 1'($urandom);
         tick();
      end
      checks++;
      if (halted_s !== 1'b1 || exec_cnt != ProgLen) begin
         errors++;
         $display("FAIL step_ignored: got halted=%b execs=%0d want 1 %0d", halted_s, exec_cnt,
                  ProgLen);
      end
`endif
      step_mode = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      halt_req = 1'b0;
      step_mode = 1'b0;
      step = 1'b0;
      mem_valid = 1'b0;
      mem_data = '0;
      sel = 1'b0;
      rom[0] = 9'h0A1;
      for (int i = 1; i < ProgLen; i++) rom[i] = 9'($urandom);
      test_reset();
      test_first_fetch();
      test_random_latency();
      test_wrap();
      test_halt_req();
      test_timeout();
      test_start_rules();
      test_step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
